// File: rtl/irq_dispatch.sv
// irq_dispatch: sequential front end for the 8:3 priority-encoder stage.
//
// Raw request lines are edge-detected. Each 0->1 transition latches a
// pending bit. Pending bits that pass the per-source mask are eligible, and
// the highest-index eligible source is offered downstream over a valid/ready
// handshake. When the offer is accepted, that source's pending bit is
// cleared. A sticky per-source flag records any request that arrives while
// the same source is still pending.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst        in   asynchronous, active-high reset
//   req        in   [N-1:0] raw request lines (rising edge = request)
//   mask       in   [N-1:0] per-source enable (1 = eligible for dispatch)
//   ena        in   dispatch enable (0 = no new offer is started)
//   irq_valid  out  offer valid
//   irq_id     out  [ID_W-1:0] index of the offered source
//   irq_ready  in   consumer accepts the offer
//   pend       out  [N-1:0] pending register, direct from flops
//   ovf        out  [N-1:0] sticky per-source lost-request flags
//   clr_ovf    in   clears all ovf bits (a same-cycle set wins)
//
// Build option:
//   IRQ_DISPATCH_SYNC_EN  when defined, req passes through a 2-flop
//                         synchronizer ahead of edge detect. This adds
//                         2 cycles of request latency.

module irq_dispatch #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    input  logic            ena,
    output logic            irq_valid,
    output logic [ID_W-1:0] irq_id,
    input  logic            irq_ready,
    output logic [N-1:0]    pend,
    output logic [N-1:0]    ovf,
    input  logic            clr_ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    req_s;
    logic [N-1:0]    req_q;
    logic [N-1:0]    rise;
    logic [N-1:0]    pend_q, pend_d;
    logic [N-1:0]    ovf_q, ovf_d;
    logic [N-1:0]    elig;
    logic [N-1:0]    clr_vec;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] sel;
    logic            any_elig;
    logic            accept;

`ifdef IRQ_DISPATCH_SYNC_EN
    logic [N-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req;
`endif

    // Edge detect: a level held high produces exactly one rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_s;
        end
    end

    assign rise     = req_s & ~req_q;
    assign elig     = pend_q & mask;
    assign any_elig = |elig;
    assign accept   = (state_q == OFFER) && irq_ready;

    // Highest-index eligible source wins: later iterations override earlier ones.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (elig[i]) begin
                sel = ID_W'(i);
            end
        end
    end

    // One-hot mask of the bit being served this cycle, empty when no accept.
    always_comb begin
        clr_vec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (accept && (id_q == ID_W'(i))) begin
                clr_vec[i] = 1'b1;
            end
        end
    end

    // A set overrides a clear in the same cycle. A re-rise on the served bit
    // is therefore a fresh request, not a lost one.
    assign pend_d = rise | (pend_q & ~clr_vec);
    assign ovf_d  = (rise & pend_q & ~clr_vec) | (ovf_q & {N{~clr_ovf}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    // Dispatch FSM: an offer, once made, ignores mask/ena/req until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        irq_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena && any_elig) begin
                    id_d    = sel;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                irq_valid = 1'b1;
                if (irq_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign irq_id = id_q;
    assign pend   = pend_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Testbench for irq_dispatch: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the dispatcher.

module tb_irq_dispatch;

    localparam int N    = 8;
    localparam int ID_W = 3;
`ifdef IRQ_DISPATCH_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            ena;
    logic            irq_valid;
    logic [ID_W-1:0] irq_id;
    logic            irq_ready;
    logic [N-1:0]    pend;
    logic [N-1:0]    ovf;
    logic            clr_ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit [N-1:0] m_prev, m_pend, m_ovf, m_s1, m_s2;
    bit         m_offer;
    int         m_id;

    irq_dispatch #(.N(N), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .ena(ena),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready),
        .pend(pend), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_ovf = '0; m_s1 = '0; m_s2 = '0;
        m_offer = 1'b0; m_id = 0;
    endtask

    // One clock of the dispatcher as described by its rules.
    task automatic model_step();
        bit [N-1:0] r, np, no;
        bit acc;
        int best;
        if (LAT == 2) begin
            r = m_s2; m_s2 = m_s1; m_s1 = req;
        end else begin
            r = req;
        end
        acc = m_offer && irq_ready;
        for (int i = 0; i < N; i++) begin
            bit up, served;
            up     = r[i] && !m_prev[i];
            served = acc && (m_id == i);
            no[i]  = (up && m_pend[i] && !served) ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[i]);
            np[i]  = up ? 1'b1 : (served ? 1'b0 : m_pend[i]);
        end
        if (m_offer) begin
            if (irq_ready) m_offer = 1'b0;
        end else if (ena) begin
            best = -1;
            for (int i = 0; i < N; i++) if (m_pend[i] && mask[i]) best = i;
            if (best >= 0) begin
                m_offer = 1'b1;
                m_id    = best;
            end
        end
        m_pend = np;
        m_ovf  = no;
        m_prev = r;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; mask = 8'hFF; ena = 1'b1; irq_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        tick(); tick();
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
        n_cmp++; if (irq_id !== 3'd0) begin n_err++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
        n_cmp++; if (pend !== 8'h00) begin n_err++; $display("FAIL reset_pend got=%h exp=00", pend); end
        n_cmp++; if (ovf !== 8'h00) begin n_err++; $display("FAIL reset_ovf got=%h exp=00", ovf); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req = 8'h20; tick(); req = '0;
        repeat (LAT) tick();
        n_cmp++; if (pend !== 8'h20) begin n_err++; $display("FAIL single_pend got=%h exp=20", pend); end
        n_cmp++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL single_prevalid got=%b exp=0", irq_valid); end
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd5) begin n_err++; $display("FAIL single_offer got=%b/%0d exp=1/5", irq_valid, irq_id); end
        irq_ready = 1'b1; tick(); irq_ready = 1'b0;
        n_cmp++; if (pend !== 8'h00 || irq_valid !== 1'b0) begin n_err++; $display("FAIL single_accept got=%h/%b exp=00/0", pend, irq_valid); end
    endtask

    task automatic test_two();
        irq_ready = 1'b1;
        req = 8'h81; tick(); req = '0;
        repeat (LAT) tick();
        n_cmp++; if (pend !== 8'h81) begin n_err++; $display("FAIL two_pend got=%h exp=81", pend); end
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin n_err++; $display("FAIL two_first got=%b/%0d exp=1/7", irq_valid, irq_id); end
        tick();
        n_cmp++; if (irq_valid !== 1'b0 || pend !== 8'h01) begin n_err++; $display("FAIL two_bubble got=%b/%h exp=0/01", irq_valid, pend); end
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd0) begin n_err++; $display("FAIL two_second got=%b/%0d exp=1/0", irq_valid, irq_id); end
        tick();
        n_cmp++; if (pend !== 8'h00 || ovf !== 8'h00 || irq_valid !== 1'b0) begin n_err++; $display("FAIL two_end got=%h/%h/%b exp=00/00/0", pend, ovf, irq_valid); end
        irq_ready = 1'b0;
    endtask

    task automatic test_mask();
        mask = 8'h0F;
        req = 8'h44; tick(); req = '0;
        repeat (LAT) tick();
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin n_err++; $display("FAIL mask_offer got=%b/%0d exp=1/2", irq_valid, irq_id); end
        irq_ready = 1'b1; tick(); irq_ready = 1'b0;
        tick();
        n_cmp++; if (irq_valid !== 1'b0 || pend !== 8'h40) begin n_err++; $display("FAIL mask_hold got=%b/%h exp=0/40", irq_valid, pend); end
        mask = 8'hFF; tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd6) begin n_err++; $display("FAIL mask_release got=%b/%0d exp=1/6", irq_valid, irq_id); end
        irq_ready = 1'b1; tick(); irq_ready = 1'b0;
        n_cmp++; if (pend !== 8'h00) begin n_err++; $display("FAIL mask_end got=%h exp=00", pend); end
    endtask

    task automatic test_hold_ovf();
        int acc = 0;
        req = 8'h08; irq_ready = 1'b1;
        for (int c = 0; c < 10 + LAT; c++) begin
            if (irq_valid && irq_ready) acc++;
            tick();
        end
        n_cmp++; if (acc !== 1) begin n_err++; $display("FAIL hold_offers got=%0d exp=1", acc); end
        irq_ready = 1'b0;
        req = 8'h00; tick(); req = 8'h08; tick();
        repeat (LAT) tick();
        n_cmp++; if (pend !== 8'h08 || ovf !== 8'h00) begin n_err++; $display("FAIL hold_rerise got=%h/%h exp=08/00", pend, ovf); end
        req = 8'h00; tick(); req = 8'h08; tick();
        repeat (LAT) tick();
        n_cmp++; if (ovf !== 8'h08) begin n_err++; $display("FAIL ovf_set got=%h exp=08", ovf); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        n_cmp++; if (ovf !== 8'h00) begin n_err++; $display("FAIL ovf_clear got=%h exp=00", ovf); end
        req = 8'h00; irq_ready = 1'b1; tick(); irq_ready = 1'b0;
        n_cmp++; if (pend !== 8'h00) begin n_err++; $display("FAIL hold_end got=%h exp=00", pend); end
    endtask

    task automatic test_no_preempt();
        req = 8'h02; tick(); req = '0;
        repeat (LAT) tick();
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd1) begin n_err++; $display("FAIL np_offer got=%b/%0d exp=1/1", irq_valid, irq_id); end
        req = 8'h80; ena = 1'b0; tick(); req = '0;
        repeat (LAT + 2) tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd1 || pend !== 8'h82) begin n_err++; $display("FAIL np_stable got=%b/%0d/%h exp=1/1/82", irq_valid, irq_id, pend); end
        irq_ready = 1'b1; tick(); irq_ready = 1'b0;
        repeat (3) tick();
        n_cmp++; if (irq_valid !== 1'b0 || pend !== 8'h80) begin n_err++; $display("FAIL np_disabled got=%b/%h exp=0/80", irq_valid, pend); end
        ena = 1'b1; tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin n_err++; $display("FAIL np_next got=%b/%0d exp=1/7", irq_valid, irq_id); end
        irq_ready = 1'b1; tick(); irq_ready = 1'b0;
    endtask

    task automatic test_same_cycle_and_reset();
        req = 8'h10; tick(); req = '0;
        repeat (LAT) tick();
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd4) begin n_err++; $display("FAIL sc_offer got=%b/%0d exp=1/4", irq_valid, irq_id); end
        req = 8'h10;
        repeat (LAT) tick();
        irq_ready = 1'b1; tick(); irq_ready = 1'b0; req = '0;
        n_cmp++; if (pend !== 8'h10 || ovf !== 8'h00 || irq_valid !== 1'b0) begin n_err++; $display("FAIL sc_setwins got=%h/%h/%b exp=10/00/0", pend, ovf, irq_valid); end
        tick();
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd4) begin n_err++; $display("FAIL sc_reoffer got=%b/%0d exp=1/4", irq_valid, irq_id); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (irq_valid !== 1'b0 || pend !== 8'h00 || ovf !== 8'h00) begin n_err++; $display("FAIL async_reset got=%b/%h/%h exp=0/00/00", irq_valid, pend, ovf); end
        model_reset();
        tick(); rst = 1'b0; tick();
        n_cmp++; if (irq_valid !== 1'b0 || pend !== 8'h00) begin n_err++; $display("FAIL post_reset got=%b/%h exp=0/00", irq_valid, pend); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req       = req ^ (N'($urandom) & N'($urandom));
            mask      = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
            ena       = ($urandom_range(0, 4) != 0);
            irq_ready = $urandom_range(0, 1);
            clr_ovf   = ($urandom_range(0, 19) == 0);
            tick();
            n_cmp++; if (irq_valid !== m_offer) begin n_err++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, irq_valid, m_offer); end
            n_cmp++; if (irq_id !== ID_W'(m_id)) begin n_err++; $display("FAIL rnd_id c=%0d got=%0d exp=%0d", c, irq_id, m_id); end
            n_cmp++; if (pend !== m_pend) begin n_err++; $display("FAIL rnd_pend c=%0d got=%h exp=%h", c, pend, m_pend); end
            n_cmp++; if (ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c=%0d got=%h exp=%h", c, ovf, m_ovf); end
        end
        req = '0; irq_ready = 1'b0; clr_ovf = 1'b0; mask = 8'hFF; ena = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_mask();
        test_hold_ovf();
        test_no_preempt();
        test_same_cycle_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
